// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, scan state encoding and glyphs for the seven-segment display
package seg_pkg;

  localparam logic [7:0] ANODE_OFF  = 8'hFF;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam int         NUM_DIGITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_e;

  // Active-low glyphs, bit7 = dp, bit0 = segment a
  localparam logic [7:0] SEG_0    = 8'hC0;
  localparam logic [7:0] SEG_1    = 8'hF9;
  localparam logic [7:0] SEG_2    = 8'hA4;
  localparam logic [7:0] SEG_3    = 8'hB0;
  localparam logic [7:0] SEG_P    = 8'b10001100;
  localparam logic [7:0] SEG_DASH = 8'hBF;

  function automatic logic anode_legal(input logic [7:0] anode);
    return $countones(~anode) <= 1;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - display scan bus between pattern source/controller and scan driver
interface seg_scan_if;
  logic       enable;
  logic [7:0] cathode_in;
  logic [2:0] refreshcounter;
  logic [7:0] anode;
  logic [7:0] cathode;
  logic       frame_done;

  modport master (
    output enable, cathode_in,
    input  refreshcounter, anode, cathode, frame_done
  );

  modport slave (
    input  enable, cathode_in,
    output refreshcounter, anode, cathode, frame_done
  );
endinterface

// File: rtl/seg_scan_driver_slot_timer.sv
// rtl/seg_scan_driver_slot_timer.sv - per-digit slot counter with blank-end and slot-end strobes
module slot_timer #(
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic blank_end,
  output logic slot_end
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + CW'(1);
    if (clear || count_q == SLOT_LAST) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign blank_end = (count_q == BLANK_LAST);
  assign slot_end  = (count_q == SLOT_LAST);

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - 8-digit multiplexed seven-segment scan with per-slot blanking
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic  clk,
  input  logic  reset,
  seg_scan_if.slave bus
);

  scan_state_e state_q, state_d;
  logic [2:0]  refresh_q, refresh_d;
  logic [7:0]  anode_q, anode_d;
  logic [7:0]  cathode_q, cathode_d;
  logic        frame_done_q, frame_done_d;
  logic        timer_clear, blank_end, slot_end;

  assign timer_clear = (state_q == IDLE) || !bus.enable;

  slot_timer #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_slot_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (timer_clear),
    .blank_end (blank_end),
    .slot_end  (slot_end)
  );

  always_comb begin
    state_d      = state_q;
    refresh_d    = refresh_q;
    anode_d      = anode_q;
    cathode_d    = cathode_q;
    frame_done_d = 1'b0;
    if (!bus.enable) begin
      state_d   = IDLE;
      refresh_d = '0;
      anode_d   = ANODE_OFF;
      cathode_d = SEG_BLANK;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = BLANK;
          refresh_d = '0;
          anode_d   = ANODE_OFF;
          cathode_d = SEG_BLANK;
        end
        BLANK: begin
          anode_d   = ANODE_OFF;
          cathode_d = SEG_BLANK;
          if (blank_end) begin
            state_d   = SHOW;
            cathode_d = bus.cathode_in;
            anode_d   = ~(8'b1 << refresh_q);
          end
        end
        SHOW: begin
          // Pattern was latched at capture; only the slot boundary matters here
          if (slot_end) begin
            state_d      = BLANK;
            refresh_d    = refresh_q + 3'd1;
            anode_d      = ANODE_OFF;
            cathode_d    = SEG_BLANK;
            frame_done_d = (refresh_q == 3'd7);
          end
        end
        default: begin
          state_d   = IDLE;
          refresh_d = '0;
          anode_d   = ANODE_OFF;
          cathode_d = SEG_BLANK;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      refresh_q    <= '0;
      anode_q      <= ANODE_OFF;
      cathode_q    <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      refresh_q    <= refresh_d;
      anode_q      <= anode_d;
      cathode_q    <= cathode_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (anode_legal(anode_q));
      assert (anode_q == ANODE_OFF || anode_q == ~(8'b1 << refresh_q));
      assert (cathode_q == SEG_BLANK || anode_q != ANODE_OFF);
    end
  end

  assign bus.refreshcounter = refresh_q;
  assign bus.anode          = anode_q;
  assign bus.cathode        = cathode_q;
  assign bus.frame_done     = frame_done_q;

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Drives the 8-digit multiplexed seven-segment display from a combinational cathode pattern source, such as the turn/status message generator. It owns the digit scan: it produces the 3-bit refreshcounter that selects the digit pattern, samples the returned 8-bit cathode pattern, and drives active-low anodes and cathodes to the board. A blanking interval at the start of each digit slot prevents ghosting.

Parameters:
PRESCALE, 100000, clk cycles per digit slot (100 MHz clock -> 1 kHz per digit, 125 Hz frame); legal range 4..2^20.
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; legal range 1..PRESCALE-2.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  1 = scan display; 0 = display dark and scan held at digit 0
cathode_in  input  8  segment pattern for the digit selected by refreshcounter (active-low, bit7 = dp)
refreshcounter  output  3  digit index to the pattern source, 0 = rightmost digit
anode  output  8  active-low digit enables; anode[i] = 0 lights digit i
cathode  output  8  active-low segments to the board (registered)
frame_done  output  1  one-cycle pulse after digit 7's slot completes

Behaviour:
- Reset and timing rules:
  - Clock is clk. Reset is synchronous and active-high, sampled on the clk rising edge.
  - Reset values: refreshcounter = 0, anode = 8'hFF, cathode = 8'hFF, frame_done = 0, slot counter = 0, state = IDLE.
  - Reset takes priority over enable at all times.
  - All outputs are registered; no combinational path from input to output.
- State machine (states IDLE, BLANK, SHOW):
  - IDLE: anode = FF, cathode = FF, slot counter = 0, refreshcounter = 0. Go to BLANK on the first cycle enable = 1.
  - BLANK: anode = FF, cathode = FF. The slot counter counts 0..BLANK_CYCLES-1.
  - BLANK -> SHOW: on the cycle the count reaches BLANK_CYCLES-1, register cathode <= cathode_in and anode <= ~(8'b1 << refreshcounter). Both take effect together on the next edge.
  - SHOW: anode and cathode hold the captured values for the rest of the slot. cathode_in changes during SHOW are ignored; a mode change on the pattern source appears at the next slot.
  - SHOW -> BLANK: on the cycle the count reaches PRESCALE-1, set slot counter <= 0, refreshcounter <= refreshcounter + 1 (mod 8), anode <= FF, cathode <= FF.
  - Wrap 7 -> 0: frame_done = 1 for exactly that one cycle, aligned with the first BLANK cycle of digit 0.
- Slot timing:
  - Each digit slot is exactly PRESCALE cycles.
  - The digit is lit for PRESCALE - BLANK_CYCLES cycles: the capture edge lands at the end of count BLANK_CYCLES-1.
  - refreshcounter changes only at slot boundaries, so the pattern source has the whole blank interval to settle.
- Disable: enable = 0 in any state -> next cycle IDLE with all IDLE values, including mid-slot. frame_done is not pulsed on disable.
- Re-enable always restarts at digit 0 with a full blank interval.
- Width rules:
  - The slot counter is clog2(PRESCALE) bits.
  - Comparisons use constants PRESCALE-1 and BLANK_CYCLES-1 at counter width.
  - refreshcounter wraps naturally at 3 bits.
- Invariants, checked by assertions:
  - anode is FF or has exactly one 0.
  - anode != FF implies the zero bit index equals refreshcounter.
  - cathode != FF implies anode != FF.

Decomposition:
- Shared package seg_pkg:
  - constants ANODE_OFF = 8'hFF and SEG_BLANK = 8'hFF;
  - NUM_DIGITS = 8;
  - scan state encoding {IDLE, BLANK, SHOW};
  - segment glyph constants for reuse by pattern generators, e.g. SEG_P = 8'b10001100.
- One sub-module, slot_timer:
  - parameterised by PRESCALE and BLANK_CYCLES;
  - inputs clk, reset, clear;
  - outputs blank_end and slot_end, single-cycle strobes.
  - The FSM and digit counter stay in seg_scan_driver.

Test Plan:
1. Reset: PRESCALE=8, BLANK_CYCLES=2, enable=1. Assert reset for 3 cycles mid-scan -> anode=FF, cathode=FF, refreshcounter=0, frame_done=0 on the cycle after the reset edge.
2. Single slot timing: enable rises with cathode_in tied to 8'hF9.
   - Cycles 1-2: anode=FF, cathode=FF.
   - Cycles 3-8: anode=8'hFE, cathode=8'hF9.
   - Cycle 9: refreshcounter=1, anode=FF.
3. Full frame: cathode_in driven by a model returning 8'hC0|index.
   - Each digit i shows anode=~(1<<i) with cathode=8'hC0|i.
   - frame_done pulses once every 64 cycles, coincident with refreshcounter 7->0.
4. Mid-slot pattern change: cathode_in toggles from 8'h92 to 8'h86 during SHOW of digit 3 -> cathode stays 8'h92 until the slot ends; digit 4 captures the new value.
5. Disable mid-SHOW: enable=0 at digit 5 -> next cycle anode=FF, cathode=FF, refreshcounter=0. Re-enable -> digit 0 with a 2-cycle blank first; no spurious frame_done.
6. Boundary parameters: PRESCALE=4, BLANK_CYCLES=2 -> lit 2 of every 4 cycles; frame_done every 32 cycles; one-hot anode assertion holds throughout.
